// File: rtl/spike_fifo_arbiter.sv
// rtl/spike_fifo_arbiter.sv - round-robin burst drain of spike FIFOs onto one spike bus
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   enable             gates the start of new pops
//   src_mask           per-source arbitration enable
//   src_empty          empty flags of the source FIFOs
//   src_rd_data        show-ahead read words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_rd_en          one-hot pop strobe (combinational)
//   out_valid/ready    registered output handshake
//   out_data, out_src  spike word and the index of the source it came from
//   busy               output word pending or burst open
module spike_fifo_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int SRC_ID_WIDTH = 2,
    parameter int BURST_LEN    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data,
    output logic [NUM_SRC-1:0]            src_rd_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_ID_WIDTH-1:0]       out_src,
    output logic                          busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]              state;
    logic [SRC_ID_WIDTH-1:0] grant_ptr;
    logic [CNT_W-1:0]        burst_cnt;

    logic [NUM_SRC-1:0]      eligible;
    logic                    any_elig;
    logic                    load;
    logic                    cont;
    logic                    pop;
    logic [SRC_ID_WIDTH-1:0] rr_pick;
    logic [SRC_ID_WIDTH-1:0] winner;
    logic [DATA_WIDTH-1:0]   sel_data;

    assign eligible = ~src_empty & src_mask;
    assign any_elig = |eligible;
    // The output register may take a new word when empty or being drained this cycle.
    assign load     = enable && (!out_valid || out_ready);

    // Round-robin search from grant_ptr+1 upward; scanning from the farthest
    // candidate down lets the nearest eligible source overwrite the pick, so
    // grant_ptr itself (offset NUM_SRC) ends up with the lowest priority.
    always_comb begin
        rr_pick = grant_ptr;
        for (int k = NUM_SRC; k >= 1; k--) begin
            int sum;
            sum = int'(grant_ptr) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            if (eligible[SRC_ID_WIDTH'(sum)]) begin
                rr_pick = SRC_ID_WIDTH'(sum);
            end
        end
    end

    assign cont     = (state == ST_BURST) && eligible[grant_ptr]
                      && (burst_cnt < CNT_W'(BURST_LEN));
    assign winner   = cont ? grant_ptr : rr_pick;
    assign pop      = load && any_elig;
    assign sel_data = src_rd_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        src_rd_en = '0;
        if (rst_n && pop) begin
            src_rd_en[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_ptr <= SRC_ID_WIDTH'(NUM_SRC - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            if (any_elig) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= winner;
                grant_ptr <= winner;
                state     <= ST_BURST;
                burst_cnt <= cont ? (burst_cnt + CNT_W'(1)) : CNT_W'(1);
            end else begin
                out_valid <= 1'b0;
                state     <= ST_IDLE;
                burst_cnt <= '0;
            end
        end else if (out_ready) begin
            // enable low: retire an accepted word without starting a new pop,
            // leaving grant_ptr and burst_cnt frozen.
            out_valid <= 1'b0;
        end
    end

    assign busy = out_valid || (state == ST_BURST);

endmodule
